clock_time_core: RTL and testbench
==================================

Name: clock_time_core

Overview:
Timekeeping datapath directly downstream of the UI state machine. It consumes that block's single-cycle increment enables, load strobe and display mode. It keeps the running HH:MM:SS time, edit registers for setting the time, and alarm registers. It also divides sys_clk down to a 1 Hz tick and raises the alarm ring output.

Parameters:
CLK_HZ, 50000000, sys_clk frequency; the prescaler wraps every CLK_HZ cycles (benches use 4)
RING_SECONDS, 60, number of seconds the alarm rings unless stopped
SNOOZE_SECONDS, 300, snooze delay in seconds (used only with ALARM_SNOOZE_EN)

Ports:
sys_clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
display_mode  input  3  UI state: 0 display, 1 set hours, 2 set minutes, 3 set alarm hours, 4 set alarm minutes
inc_current_hours_en  input  1  one-cycle pulse: edit_hh+1
inc_current_minutes_en  input  1  one-cycle pulse: edit_mm+1
inc_alarm_hours_en  input  1  one-cycle pulse: alarm_hh+1
inc_alarm_minutes_en  input  1  one-cycle pulse: alarm_mm+1
load_time_en  input  1  one-cycle pulse: copy edit registers into running time
alarm_enable  input  1  level: arms the alarm compare
alarm_stop  input  1  one-cycle pulse: silences the ringing alarm
snooze_btn  input  1  one-cycle pulse: snooze (only with ALARM_SNOOZE_EN; ignored otherwise)
time_hh  output  5  running hours, 0-23
time_mm  output  6  running minutes, 0-59
time_ss  output  6  running seconds, 0-59
edit_hh  output  5  edit hours, 0-23
edit_mm  output  6  edit minutes, 0-59
alarm_hh  output  5  alarm hours, 0-23
alarm_mm  output  6  alarm minutes, 0-59
sec_tick  output  1  registered one-cycle pulse, once per second
alarm_ring  output  1  registered level, high while ringing

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0; prescaler 0; ring counter and snooze counter 0.
- Prescaler: counts 0..CLK_HZ-1. When it wraps, sec_tick is 1 on the next cycle.
- Running time advances by 1 s on the same edge that sec_tick is registered.
  - ss wraps 59->0 and carries to mm.
  - mm wraps 59->0 and carries to hh.
  - hh wraps 23->0. So 23:59:59 -> 00:00:00.
- Edit registers:
  - While display_mode==0, edit_hh/edit_mm track time_hh/time_mm every cycle (one-cycle lag).
  - Otherwise they are frozen and change only on an inc pulse.
  - inc wraps: hours 23->0, minutes 59->0, with no carry between them.
- Alarm registers change only on an inc_alarm pulse, with the same wrap rules. They are never touched by the running time.
- load_time_en: on the next edge, time_hh/time_mm <= edit_hh/edit_mm, time_ss <= 0, and the prescaler is cleared.
  - Load beats a simultaneous tick: the tick is discarded.
  - Load uses the edit value before any same-cycle inc.
- Display_mode value 5-7: treated as 0.
- Alarm trigger: fires when a tick (not a load) moves the time to alarm_hh:alarm_mm:00 and alarm_enable=1.
  - alarm_ring goes high on the edge after that tick.
  - The ring counter is loaded with RING_SECONDS.
- Ringing:
  - The ring counter decrements on each tick; alarm_ring drops on the tick that takes it to 0.
  - alarm_stop, or alarm_enable going low, clears alarm_ring and the counter on the next edge.
  - alarm_stop beats a same-cycle trigger.
  - A re-trigger while already ringing reloads the counter.
- A mid-operation reset aborts ringing and clears the time.

Optional Feature:
ALARM_SNOOZE_EN
- Defined: snooze_btn while alarm_ring=1 clears alarm_ring on the next edge and loads the snooze counter with SNOOZE_SECONDS.
  - The snooze counter decrements on each tick.
  - On the tick where it reaches 0, the alarm re-triggers: alarm_ring=1 and the ring counter reloads.
  - Snooze repeats without limit.
  - alarm_stop, or alarm_enable low, cancels a pending snooze.
  - snooze_btn while not ringing is ignored.
- Undefined: snooze_btn is ignored; there is no snooze counter logic.

Test Plan:
- CLK_HZ=4, reset, run 12 cycles -> sec_tick pulses every 4 cycles; time reaches 00:00:03.
- Load edit 23:59 via display_mode=1, 23 hour incs and 59 minute incs, then load_time_en, then run 60 ticks -> time 00:00:00; the first sec_tick comes 4 cycles after the load.
- display_mode=1 with 25 inc_current_hours pulses -> edit_hh=1, time_hh unchanged.
- alarm 00:01, alarm_enable=1, time from 00:00:00 -> alarm_ring rises 1 cycle after the tick into 00:01:00; it falls after 60 ticks, or 1 cycle after an alarm_stop pulse.
- load_time_en and the prescaler wrap in the same cycle -> time_ss=0 and no sec_tick that cycle.
- ALARM_SNOOZE_EN with SNOOZE_SECONDS=5: snooze while ringing -> alarm_ring drops, then re-rises 5 ticks later; with the macro undefined, alarm_ring stays high.

Source files
------------

// File: rtl/clock_time_core.sv
// rtl/clock_time_core.sv - HH:MM:SS timekeeping, time/alarm edit registers, 1 Hz prescaler and alarm ring
//
// Purpose:
//   Keeps the running clock, the edit copy used while the user sets the time,
//   and the alarm setting. It divides sys_clk down to a once-per-second tick
//   and drives the alarm ring output.
//
// Optional feature macro: ALARM_SNOOZE_EN (adds the snooze counter and the snooze_btn behaviour)
//
// Ports:
//   sys_clk, rst_n          clock, asynchronous active-low reset
//   display_mode[2:0]       UI state (0 display, 1/2 set time h/m, 3/4 set alarm h/m, 5-7 as 0)
//   inc_*_en                single-cycle increment pulses for edit and alarm fields
//   load_time_en            copy edit_hh:edit_mm into the running time, seconds and prescaler to 0
//   alarm_enable            level, arms the alarm compare
//   alarm_stop, snooze_btn  single-cycle pulses
//   time_hh/mm/ss           running time
//   edit_hh/mm              edit registers
//   alarm_hh/mm             alarm registers
//   sec_tick                registered one-cycle pulse per second
//   alarm_ring              registered level, high while ringing
module clock_time_core #(
  parameter int CLK_HZ         = 50000000,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [2:0] display_mode,
  input  logic       inc_current_hours_en,
  input  logic       inc_current_minutes_en,
  input  logic       inc_alarm_hours_en,
  input  logic       inc_alarm_minutes_en,
  input  logic       load_time_en,
  input  logic       alarm_enable,
  input  logic       alarm_stop,
  input  logic       snooze_btn,
  output logic [4:0] time_hh,
  output logic [5:0] time_mm,
  output logic [5:0] time_ss,
  output logic [4:0] edit_hh,
  output logic [5:0] edit_mm,
  output logic [4:0] alarm_hh,
  output logic [5:0] alarm_mm,
  output logic       sec_tick,
  output logic       alarm_ring
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RW = (RING_SECONDS > 0) ? $clog2(RING_SECONDS + 1) : 1;
  localparam int SW = (SNOOZE_SECONDS > 0) ? $clog2(SNOOZE_SECONDS + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v >= 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic          sec_tick_q, sec_tick_d;
  logic [4:0]    time_hh_q, time_hh_d;
  logic [5:0]    time_mm_q, time_mm_d;
  logic [5:0]    time_ss_q, time_ss_d;
  logic [4:0]    edit_hh_q, edit_hh_d;
  logic [5:0]    edit_mm_q, edit_mm_d;
  logic [4:0]    alarm_hh_q, alarm_hh_d;
  logic [5:0]    alarm_mm_q, alarm_mm_d;
  logic          alarm_ring_q, alarm_ring_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;

  logic wrap;
  logic tick;
  logic track_time;
  logic trigger;
  logic silence;
  logic snooze_press;
  logic snooze_fire;

  // A load wins over a coincident prescaler wrap, so that second is dropped.
  assign wrap       = (presc_q == PRESC_MAX);
  assign tick       = wrap && !load_time_en;
  assign track_time = (display_mode == 3'd0) || (display_mode > 3'd4);
  assign silence    = alarm_stop || !alarm_enable;

  // sec_tick_q marks that the previous edge was a real tick (loads never set it),
  // so the compare only fires when counting, not loading, reaches the alarm time.
  assign trigger = sec_tick_q && alarm_enable &&
                   (time_hh_q == alarm_hh_q) && (time_mm_q == alarm_mm_q) &&
                   (time_ss_q == 6'd0);

`ifdef ALARM_SNOOZE_EN
  logic [SW-1:0] snooze_cnt_q, snooze_cnt_d;

  assign snooze_press = snooze_btn && alarm_ring_q;
  assign snooze_fire  = tick && (snooze_cnt_q == SW'(1));

  always_comb begin
    snooze_cnt_d = snooze_cnt_q;
    if (silence) begin
      snooze_cnt_d = '0;
    end else if (snooze_press) begin
      snooze_cnt_d = SW'(SNOOZE_SECONDS);
    end else if (trigger) begin
      snooze_cnt_d = '0;
    end else if (tick && (snooze_cnt_q != '0)) begin
      snooze_cnt_d = snooze_cnt_q - SW'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      snooze_cnt_q <= '0;
    end else begin
      snooze_cnt_q <= snooze_cnt_d;
    end
  end
`else
  logic [SW:0] unused_snooze;
  assign unused_snooze = {snooze_btn, SW'(SNOOZE_SECONDS)};
  assign snooze_press  = 1'b0;
  assign snooze_fire   = 1'b0;
`endif

  always_comb begin
    presc_d    = wrap || load_time_en ? '0 : presc_q + PW'(1);
    sec_tick_d = tick;

    time_hh_d = time_hh_q;
    time_mm_d = time_mm_q;
    time_ss_d = time_ss_q;
    if (load_time_en) begin
      time_hh_d = edit_hh_q;
      time_mm_d = edit_mm_q;
      time_ss_d = 6'd0;
    end else if (tick) begin
      time_ss_d = inc60(time_ss_q);
      if (time_ss_q == 6'd59) begin
        time_mm_d = inc60(time_mm_q);
        if (time_mm_q == 6'd59) begin
          time_hh_d = inc24(time_hh_q);
        end
      end
    end

    // Edit registers shadow the running time in display mode, otherwise only the
    // inc pulses move them; hours and minutes wrap independently.
    edit_hh_d = edit_hh_q;
    edit_mm_d = edit_mm_q;
    if (track_time) begin
      edit_hh_d = time_hh_q;
      edit_mm_d = time_mm_q;
    end else begin
      if (inc_current_hours_en)   edit_hh_d = inc24(edit_hh_q);
      if (inc_current_minutes_en) edit_mm_d = inc60(edit_mm_q);
    end

    alarm_hh_d = inc_alarm_hours_en   ? inc24(alarm_hh_q) : alarm_hh_q;
    alarm_mm_d = inc_alarm_minutes_en ? inc60(alarm_mm_q) : alarm_mm_q;

    alarm_ring_d = alarm_ring_q;
    ring_cnt_d   = ring_cnt_q;
    if (silence || snooze_press) begin
      alarm_ring_d = 1'b0;
      ring_cnt_d   = '0;
    end else if (trigger || snooze_fire) begin
      alarm_ring_d = 1'b1;
      ring_cnt_d   = RW'(RING_SECONDS);
    end else if (alarm_ring_q && tick) begin
      if (ring_cnt_q <= RW'(1)) begin
        alarm_ring_d = 1'b0;
        ring_cnt_d   = '0;
      end else begin
        ring_cnt_d = ring_cnt_q - RW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      sec_tick_q   <= 1'b0;
      time_hh_q    <= '0;
      time_mm_q    <= '0;
      time_ss_q    <= '0;
      edit_hh_q    <= '0;
      edit_mm_q    <= '0;
      alarm_hh_q   <= '0;
      alarm_mm_q   <= '0;
      alarm_ring_q <= 1'b0;
      ring_cnt_q   <= '0;
    end else begin
      presc_q      <= presc_d;
      sec_tick_q   <= sec_tick_d;
      time_hh_q    <= time_hh_d;
      time_mm_q    <= time_mm_d;
      time_ss_q    <= time_ss_d;
      edit_hh_q    <= edit_hh_d;
      edit_mm_q    <= edit_mm_d;
      alarm_hh_q   <= alarm_hh_d;
      alarm_mm_q   <= alarm_mm_d;
      alarm_ring_q <= alarm_ring_d;
      ring_cnt_q   <= ring_cnt_d;
    end
  end

  assign time_hh    = time_hh_q;
  assign time_mm    = time_mm_q;
  assign time_ss    = time_ss_q;
  assign edit_hh    = edit_hh_q;
  assign edit_mm    = edit_mm_q;
  assign alarm_hh   = alarm_hh_q;
  assign alarm_mm   = alarm_mm_q;
  assign sec_tick   = sec_tick_q;
  assign alarm_ring = alarm_ring_q;

endmodule

// File: tb/tb_clock_time_core.sv
// tb/tb_clock_time_core.sv - directed vector bench for clock_time_core
module tb_clock_time_core;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] display_mode = 3'd0;
  logic       inc_current_hours_en = 1'b0;
  logic       inc_current_minutes_en = 1'b0;
  logic       inc_alarm_hours_en = 1'b0;
  logic       inc_alarm_minutes_en = 1'b0;
  logic       load_time_en = 1'b0;
  logic       alarm_enable = 1'b0;
  logic       alarm_stop = 1'b0;
  logic       snooze_btn = 1'b0;
  logic [4:0] time_hh;
  logic [5:0] time_mm;
  logic [5:0] time_ss;
  logic [4:0] edit_hh;
  logic [5:0] edit_mm;
  logic [4:0] alarm_hh;
  logic [5:0] alarm_mm;
  logic       sec_tick;
  logic       alarm_ring;

  int checks = 0;
  int errors = 0;

  clock_time_core #(
    .CLK_HZ(4),
    .RING_SECONDS(60),
    .SNOOZE_SECONDS(5)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .display_mode(display_mode),
    .inc_current_hours_en(inc_current_hours_en),
    .inc_current_minutes_en(inc_current_minutes_en),
    .inc_alarm_hours_en(inc_alarm_hours_en),
    .inc_alarm_minutes_en(inc_alarm_minutes_en),
    .load_time_en(load_time_en),
    .alarm_enable(alarm_enable),
    .alarm_stop(alarm_stop),
    .snooze_btn(snooze_btn),
    .time_hh(time_hh),
    .time_mm(time_mm),
    .time_ss(time_ss),
    .edit_hh(edit_hh),
    .edit_mm(edit_mm),
    .alarm_hh(alarm_hh),
    .alarm_mm(alarm_mm),
    .sec_tick(sec_tick),
    .alarm_ring(alarm_ring)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [2:0] mode;
    int hinc;
    int minc;
    int ahinc;
    int aminc;
    int exp_edit_hh;
    int exp_edit_mm;
    int exp_alarm_hh;
    int exp_alarm_mm;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  initial begin
    // Cumulative edits; time stays below 00:01 throughout, so time_hh is 0.
    vecs[0] = '{3'd1, 25, 0,  0,  0,  1,  0,  0, 0};
    vecs[1] = '{3'd1, 22, 0,  0,  0,  23, 0,  0, 0};
    vecs[2] = '{3'd2, 0,  59, 0,  0,  23, 59, 0, 0};
    vecs[3] = '{3'd3, 0,  0,  24, 0,  23, 59, 0, 0};
    vecs[4] = '{3'd4, 0,  0,  0,  61, 23, 59, 0, 1};

    // Reset state
    cyc(2);
    chk("reset time_hh", int'(time_hh), 0);
    chk("reset time_mm", int'(time_mm), 0);
    chk("reset time_ss", int'(time_ss), 0);
    chk("reset edit_hh", int'(edit_hh), 0);
    chk("reset edit_mm", int'(edit_mm), 0);
    chk("reset alarm_hh", int'(alarm_hh), 0);
    chk("reset alarm_mm", int'(alarm_mm), 0);
    chk("reset sec_tick", int'(sec_tick), 0);
    chk("reset alarm_ring", int'(alarm_ring), 0);
    rst_n = 1'b1;

    // Prescaler cadence: sec_tick after every 4th edge
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      chk($sformatf("sec_tick cycle %0d", k), int'(sec_tick), (k % 4 == 0) ? 1 : 0);
    end
    chk("time_ss after 12", int'(time_ss), 3);
    chk("time_mm after 12", int'(time_mm), 0);

    // Edit / alarm register vectors
    for (int v = 0; v < 5; v++) begin
      display_mode = vecs[v].mode;
      inc_current_hours_en = 1'b1;   repeat (vecs[v].hinc)  cyc(1); inc_current_hours_en = 1'b0;
      inc_current_minutes_en = 1'b1; repeat (vecs[v].minc)  cyc(1); inc_current_minutes_en = 1'b0;
      inc_alarm_hours_en = 1'b1;     repeat (vecs[v].ahinc) cyc(1); inc_alarm_hours_en = 1'b0;
      inc_alarm_minutes_en = 1'b1;   repeat (vecs[v].aminc) cyc(1); inc_alarm_minutes_en = 1'b0;
      chk($sformatf("vec%0d edit_hh", v), int'(edit_hh), vecs[v].exp_edit_hh);
      chk($sformatf("vec%0d edit_mm", v), int'(edit_mm), vecs[v].exp_edit_mm);
      chk($sformatf("vec%0d alarm_hh", v), int'(alarm_hh), vecs[v].exp_alarm_hh);
      chk($sformatf("vec%0d alarm_mm", v), int'(alarm_mm), vecs[v].exp_alarm_mm);
      chk($sformatf("vec%0d time_hh", v), int'(time_hh), 0);
    end

    // Load 23:59, then 60 ticks to midnight (n counts edges after the load)
    load_time_en = 1'b1; cyc(1); load_time_en = 1'b0;
    chk("load time_hh", int'(time_hh), 23);
    chk("load time_mm", int'(time_mm), 59);
    chk("load time_ss", int'(time_ss), 0);
    chk("load sec_tick", int'(sec_tick), 0);
    cyc(3);
    chk("post-load n3 sec_tick", int'(sec_tick), 0);
    cyc(1);
    chk("post-load n4 sec_tick", int'(sec_tick), 1);
    chk("post-load n4 time_ss", int'(time_ss), 1);
    display_mode = 3'd7;
    cyc(2);
    chk("mode7 edit_hh", int'(edit_hh), 23);
    chk("mode7 edit_mm", int'(edit_mm), 59);
    cyc(234);
    chk("midnight time_hh", int'(time_hh), 0);
    chk("midnight time_mm", int'(time_mm), 0);
    chk("midnight time_ss", int'(time_ss), 0);
    chk("midnight sec_tick", int'(sec_tick), 1);

    // Alarm 00:01 rings one cycle after the tick, lasts 60 ticks
    alarm_enable = 1'b1;
    cyc(240);
    chk("n480 time_mm", int'(time_mm), 1);
    chk("n480 time_ss", int'(time_ss), 0);
    chk("n480 alarm_ring", int'(alarm_ring), 0);
    cyc(1);
    chk("n481 alarm_ring", int'(alarm_ring), 1);
    cyc(238);
    chk("n719 alarm_ring", int'(alarm_ring), 1);
    cyc(1);
    chk("n720 alarm_ring", int'(alarm_ring), 0);

    // Alarm 00:03, stopped with alarm_stop
    inc_alarm_minutes_en = 1'b1; cyc(2); inc_alarm_minutes_en = 1'b0;
    chk("alarm_mm 3", int'(alarm_mm), 3);
    cyc(238);
    chk("n960 time_mm", int'(time_mm), 3);
    cyc(1);
    chk("n961 alarm_ring", int'(alarm_ring), 1);
    cyc(9);
    alarm_stop = 1'b1; cyc(1); alarm_stop = 1'b0;
    chk("stop alarm_ring", int'(alarm_ring), 0);
    cyc(9);
    chk("after stop alarm_ring", int'(alarm_ring), 0);

    // Load coinciding with a prescaler wrap; load to the alarm time does not ring
    cyc(3);
    load_time_en = 1'b1; cyc(1); load_time_en = 1'b0;
    chk("load+wrap time_ss", int'(time_ss), 0);
    chk("load+wrap time_mm", int'(time_mm), 3);
    chk("load+wrap sec_tick", int'(sec_tick), 0);
    cyc(1);
    chk("load no trigger", int'(alarm_ring), 0);
    cyc(3);
    chk("L+4 sec_tick", int'(sec_tick), 1);
    chk("L+4 time_ss", int'(time_ss), 1);

    // Alarm 00:04, snooze while ringing
    inc_alarm_minutes_en = 1'b1; cyc(1); inc_alarm_minutes_en = 1'b0;
    chk("alarm_mm 4", int'(alarm_mm), 4);
    cyc(235);
    chk("L+240 time_mm", int'(time_mm), 4);
    cyc(1);
    chk("L+241 alarm_ring", int'(alarm_ring), 1);
    cyc(4);
    snooze_btn = 1'b1; cyc(1); snooze_btn = 1'b0;
`ifdef ALARM_SNOOZE_EN
    chk("snooze drop", int'(alarm_ring), 0);
    cyc(17);
    chk("snooze pending", int'(alarm_ring), 0);
`else
    chk("snooze ignored", int'(alarm_ring), 1);
    cyc(17);
    chk("still ringing", int'(alarm_ring), 1);
`endif
    cyc(1);
    chk("L+264 alarm_ring", int'(alarm_ring), 1);

    // Reset while ringing
    cyc(2);
    rst_n = 1'b0;
    #1;
    chk("midreset alarm_ring", int'(alarm_ring), 0);
    chk("midreset time_mm", int'(time_mm), 0);
    chk("midreset time_ss", int'(time_ss), 0);
    chk("midreset alarm_mm", int'(alarm_mm), 0);
    cyc(1);
    rst_n = 1'b1;

    // Alarm 00:01 from reset, silenced by dropping alarm_enable
    inc_alarm_minutes_en = 1'b1; cyc(1); inc_alarm_minutes_en = 1'b0;
    cyc(240);
    chk("R241 alarm_ring", int'(alarm_ring), 1);
    alarm_enable = 1'b0; cyc(1);
    chk("disable alarm_ring", int'(alarm_ring), 0);
    alarm_enable = 1'b1; cyc(4);
    chk("reenable alarm_ring", int'(alarm_ring), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
